// File: rtl/l2_tlb_pkg.sv
// Shared types and constants for the L2 TLB lookup pipeline.
package l2_tlb_pkg;

  localparam int DEF_WAYS     = 4;
  localparam int DEF_SET_BITS = 6;
  localparam int DEF_ASID_W   = 7;
  localparam int DEF_VPN_W    = 28;

  // Entry tag storage is sized for the widest supported tag; the live tag
  // sits in the low TAG_W bits and the upper bits are held at zero.
  localparam int TAG_MAX_W = 64;

  // Tag is {asid, vpn[VPN_W-2:SET_BITS]}.
  function automatic int calc_tag_w(input int asid_w, input int vpn_w, input int set_bits);
    return asid_w + vpn_w - 1 - set_bits;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic                 u;
    logic                 sw;
    logic                 d;
  } tlb_entry_t;

endpackage

// File: rtl/l2_tlb_lookup_pipe_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and touch update.
// Node n (heap order, root = 1) is stored at bit n-1; a 0 sends the victim
// walk to the left child, a 1 to the right child.
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         bits_i,
  input  logic [$clog2(WAYS)-1:0] touch_i,
  output logic [$clog2(WAYS)-1:0] victim_o,
  output logic [WAYS-2:0]         bits_upd_o
);
  localparam int LVLS = $clog2(WAYS);

  // Follow the bits from the root down to a leaf.
  always_comb begin
    int node;
    node = 1;
    for (int l = 0; l < LVLS; l++) node = node * 2 + int'(bits_i[node-1]);
    victim_o = LVLS'(node - WAYS);
  end

  // Point every node on the touched path away from the touched way.
  always_comb begin
    int node;
    bits_upd_o = bits_i;
    node = 1;
    for (int l = LVLS - 1; l >= 0; l--) begin
      bits_upd_o[node-1] = ~touch_i[l];
      node = node * 2 + int'(touch_i[l]);
    end
  end

endmodule

// File: rtl/l2_tlb_lookup_pipe.sv
// Two-stage set-associative L2 TLB lookup with refill, ASID flush and PLRU.
module l2_tlb_lookup_pipe
  import l2_tlb_pkg::*;
#(
  parameter int WAYS     = DEF_WAYS,
  parameter int SET_BITS = DEF_SET_BITS,
  parameter int ASID_W   = DEF_ASID_W,
  parameter int VPN_W    = DEF_VPN_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [VPN_W-1:0]        req_vpn,
  input  logic                    req_store,
  input  logic [ASID_W-1:0]       req_asid,
  input  logic                    ctl_vm_enabled,
  input  logic                    ctl_bad_va,
  input  logic                    ctl_priv_s,
  input  logic                    ctl_pum,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic                    resp_miss,
  output logic                    resp_bypass,
  output logic [$clog2(WAYS)-1:0] resp_way,
  output logic [$clog2(WAYS)-1:0] resp_repl_way,
  input  logic                    refill_valid,
  input  logic [VPN_W-1:0]        refill_vpn,
  input  logic [ASID_W-1:0]       refill_asid,
  input  logic [$clog2(WAYS)-1:0] refill_way,
  input  logic                    refill_u,
  input  logic                    refill_sw,
  input  logic                    refill_d,
  input  logic                    flush_valid,
  input  logic                    flush_asid_en,
  input  logic [ASID_W-1:0]       flush_asid
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = calc_tag_w(ASID_W, VPN_W, SET_BITS);
  localparam int VTG_W = VPN_W - 1 - SET_BITS;

  typedef struct packed {
    logic [SET_BITS-1:0]  set;
    logic [TAG_MAX_W-1:0] tag;
    logic                 store;
    logic                 vm;
    logic                 bad;
    logic                 priv;
    logic                 pum;
  } s1_req_t;

  typedef struct packed {
    logic             hit;
    logic             miss;
    logic             bypass;
    logic [WAY_W-1:0] way;
    logic [WAY_W-1:0] repl;
  } resp_t;

  function automatic logic [TAG_MAX_W-1:0] mk_tag(input logic [ASID_W-1:0] a,
                                                   input logic [VTG_W-1:0]  v);
    mk_tag = '0;
    mk_tag[TAG_W-1:0] = {a, v};
  endfunction

  tlb_entry_t [WAYS-1:0] ent_q  [SETS];
  tlb_entry_t [WAYS-1:0] ent_d  [SETS];
  logic       [WAYS-2:0] plru_q [SETS];
  logic       [WAYS-2:0] plru_d [SETS];
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  s1_req_t               s1_q, s1_d;
  resp_t                 resp_q, resp_d;

  logic                  accept;
  logic [WAYS-1:0]       way_hit, way_inv;
  logic [WAY_W-1:0]      hit_way, inv_way, rd_victim, unused_rf_victim;
  logic                  any_hit, any_inv;
  logic [WAYS-2:0]       rd_upd, rf_upd;
  logic [SET_BITS-1:0]   rf_set;
  logic                  unused_vpn_msb;

  assign req_ready      = !refill_valid;
  assign accept         = req_valid & req_ready;
  assign rf_set         = refill_vpn[SET_BITS-1:0];
  assign unused_vpn_msb = req_vpn[VPN_W-1] ^ refill_vpn[VPN_W-1];

  assign resp_valid    = vld_pipe_q[1];
  assign resp_hit      = resp_q.hit;
  assign resp_miss     = resp_q.miss;
  assign resp_bypass   = resp_q.bypass;
  assign resp_way      = resp_q.way;
  assign resp_repl_way = resp_q.repl;

  // Capture the accepted request into S1 and advance the valid pipe.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], accept};
    s1_d       = s1_q;
    if (accept) begin
      s1_d.set   = req_vpn[SET_BITS-1:0];
      s1_d.tag   = mk_tag(req_asid, req_vpn[VPN_W-2:SET_BITS]);
      s1_d.store = req_store;
      s1_d.vm    = ctl_vm_enabled;
      s1_d.bad   = ctl_bad_va;
      s1_d.priv  = ctl_priv_s;
      s1_d.pum   = ctl_pum;
    end
  end

  // S1 compare against the pre-edge array contents of the selected set.
  always_comb begin
    tlb_entry_t e;
    logic match, priv_ok;
    way_hit = '0;
    way_inv = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      e          = ent_q[s1_q.set][w];
      match      = e.valid & s1_q.vm & (e.tag == s1_q.tag);
      priv_ok    = s1_q.priv ? !(s1_q.pum & e.u) : e.u;
      way_hit[w] = match & priv_ok & (!s1_q.store | (e.sw & e.d));
      way_inv[w] = !e.valid;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
      if (way_inv[w]) inv_way = WAY_W'(w);
    end
    any_hit = |way_hit;
    any_inv = |way_inv;
  end

  plru_tree #(.WAYS(WAYS)) u_plru_rd (
    .bits_i     (plru_q[s1_q.set]),
    .touch_i    (hit_way),
    .victim_o   (rd_victim),
    .bits_upd_o (rd_upd)
  );

  plru_tree #(.WAYS(WAYS)) u_plru_rf (
    .bits_i     (plru_q[rf_set]),
    .touch_i    (refill_way),
    .victim_o   (unused_rf_victim),
    .bits_upd_o (rf_upd)
  );

  // Response fields update only when S1 holds a request, otherwise hold.
  always_comb begin
    resp_d = resp_q;
    if (vld_pipe_q[0]) begin
      resp_d.bypass = !s1_q.vm;
      resp_d.hit    = any_hit | !s1_q.vm;
      resp_d.miss   = !(any_hit | !s1_q.vm) & s1_q.vm & !s1_q.bad;
      resp_d.way    = (any_hit && s1_q.vm) ? hit_way : '0;
      resp_d.repl   = any_inv ? inv_way : rd_victim;
    end
  end

  // Array next state: flush, then refill on top; refill PLRU touch wins.
  always_comb begin
    ent_d  = ent_q;
    plru_d = plru_q;
    if (flush_valid) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          if (!flush_asid_en || ent_q[s][w].tag[TAG_W-1 -: ASID_W] == flush_asid)
            ent_d[s][w].valid = 1'b0;
        end
      end
    end
    if (vld_pipe_q[0] && s1_q.vm && any_hit) plru_d[s1_q.set] = rd_upd;
    if (refill_valid) begin
      ent_d[rf_set][refill_way].valid = 1'b1;
      ent_d[rf_set][refill_way].tag   = mk_tag(refill_asid, refill_vpn[VPN_W-2:SET_BITS]);
      ent_d[rf_set][refill_way].u     = refill_u;
      ent_d[rf_set][refill_way].sw    = refill_sw;
      ent_d[rf_set][refill_way].d     = refill_d;
      plru_d[rf_set]                  = rf_upd;
    end
  end

  // State registers; reset empties the TLB and drops any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      resp_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        ent_q[s]  <= '0;
        plru_q[s] <= '0;
      end
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      resp_q     <= resp_d;
      ent_q      <= ent_d;
      plru_q     <= plru_d;
    end
  end

endmodule

// File: tb/tb_l2_tlb_lookup_pipe.sv
// Directed bench for l2_tlb_lookup_pipe at default parameters.
module tb_l2_tlb_lookup_pipe;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_store;
  logic [27:0] req_vpn;
  logic [6:0]  req_asid;
  logic        ctl_vm_enabled, ctl_bad_va, ctl_priv_s, ctl_pum;
  logic        resp_valid, resp_hit, resp_miss, resp_bypass;
  logic [1:0]  resp_way, resp_repl_way;
  logic        refill_valid, refill_u, refill_sw, refill_d;
  logic [27:0] refill_vpn;
  logic [6:0]  refill_asid;
  logic [1:0]  refill_way;
  logic        flush_valid, flush_asid_en;
  logic [6:0]  flush_asid;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_tlb_lookup_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .req_store(req_store), .req_asid(req_asid),
    .ctl_vm_enabled(ctl_vm_enabled), .ctl_bad_va(ctl_bad_va),
    .ctl_priv_s(ctl_priv_s), .ctl_pum(ctl_pum),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_miss(resp_miss),
    .resp_bypass(resp_bypass), .resp_way(resp_way), .resp_repl_way(resp_repl_way),
    .refill_valid(refill_valid), .refill_vpn(refill_vpn), .refill_asid(refill_asid),
    .refill_way(refill_way), .refill_u(refill_u), .refill_sw(refill_sw),
    .refill_d(refill_d),
    .flush_valid(flush_valid), .flush_asid_en(flush_asid_en), .flush_asid(flush_asid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one request, check latency, leave the response visible.
  task automatic lookup(input string tag, input logic [27:0] vpn, input logic [6:0] asid,
                        input logic st, input logic vm, input logic bad,
                        input logic ps, input logic pum);
    @(negedge clk);
    req_valid = 1'b1; req_vpn = vpn; req_asid = asid; req_store = st;
    ctl_vm_enabled = vm; ctl_bad_va = bad; ctl_priv_s = ps; ctl_pum = pum;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_s1_novld"}, resp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_vld"}, resp_valid, 1'b1);
  endtask

  task automatic exp_resp(input string tag, input logic hit, input logic miss,
                          input logic byp);
    chk({tag, "_hit"}, resp_hit, hit);
    chk({tag, "_miss"}, resp_miss, miss);
    chk({tag, "_byp"}, resp_bypass, byp);
  endtask

  task automatic refill(input logic [27:0] vpn, input logic [6:0] asid, input logic [1:0] way,
                        input logic u, input logic sw, input logic d);
    @(negedge clk);
    refill_valid = 1'b1; refill_vpn = vpn; refill_asid = asid; refill_way = way;
    refill_u = u; refill_sw = sw; refill_d = d;
    @(negedge clk);
    refill_valid = 1'b0;
  endtask

  task automatic flush(input logic en, input logic [6:0] asid);
    @(negedge clk);
    flush_valid = 1'b1; flush_asid_en = en; flush_asid = asid;
    @(negedge clk);
    flush_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 0; req_vpn = '0; req_store = 0; req_asid = '0;
    ctl_vm_enabled = 0; ctl_bad_va = 0; ctl_priv_s = 0; ctl_pum = 0;
    refill_valid = 0; refill_vpn = '0; refill_asid = '0; refill_way = '0;
    refill_u = 0; refill_sw = 0; refill_d = 0;
    flush_valid = 0; flush_asid_en = 0; flush_asid = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", resp_valid, 0);
    chk("rst_hit", resp_hit, 0);
    chk("rst_miss", resp_miss, 0);
    chk("rst_byp", resp_bypass, 0);
    chk("rst_way", resp_way, 0);
    chk("rst_repl", resp_repl_way, 0);
    chk("rst_ready", req_ready, 1);
    reset_n = 1'b1;

    // Cold miss in set 1
    lookup("cold", 28'h41, 7'd3, 0, 1, 0, 0, 0);
    exp_resp("cold", 0, 1, 0);
    chk("cold_repl", resp_repl_way, 0);

    // Refill way 0 (u=1 sw=1 d=0): load hits, store misses on d=0
    refill(28'h41, 7'd3, 2'd0, 1, 1, 0);
    lookup("ld", 28'h41, 7'd3, 0, 1, 0, 0, 0);
    exp_resp("ld", 1, 0, 0);
    chk("ld_way", resp_way, 0);
    @(negedge clk);
    chk("hold_vld", resp_valid, 0);
    chk("hold_hit", resp_hit, 1);
    lookup("st", 28'h41, 7'd3, 1, 1, 0, 0, 0);
    exp_resp("st", 0, 1, 0);
    chk("st_way", resp_way, 0);
    chk("st_repl", resp_repl_way, 1);

    // Fill set 1, touch way 0 then way 2 -> PLRU victim is way 1
    refill(28'h81,  7'd3, 2'd1, 1, 1, 1);
    refill(28'hC1,  7'd3, 2'd2, 1, 1, 1);
    refill(28'h101, 7'd3, 2'd3, 1, 1, 1);
    lookup("h0", 28'h41, 7'd3, 0, 1, 0, 0, 0);
    chk("h0_way", resp_way, 0);
    lookup("h2", 28'hC1, 7'd3, 0, 1, 0, 0, 0);
    exp_resp("h2", 1, 0, 0);
    chk("h2_way", resp_way, 2);
    lookup("plru", 28'h141, 7'd3, 0, 1, 0, 0, 0);
    exp_resp("plru", 0, 1, 0);
    chk("plru_repl", resp_repl_way, 1);
    refill(28'h141, 7'd3, 2'd1, 1, 1, 1);
    lookup("h1", 28'h141, 7'd3, 0, 1, 0, 0, 0);
    exp_resp("h1", 1, 0, 0);
    chk("h1_way", resp_way, 1);

    // ASID-selective flush
    refill(28'h02, 7'd5, 2'd0, 1, 1, 1);
    flush(1'b1, 7'd3);
    lookup("fl3", 28'h41, 7'd3, 0, 1, 0, 0, 0);
    exp_resp("fl3", 0, 1, 0);
    lookup("fl5", 28'h02, 7'd5, 0, 1, 0, 0, 0);
    exp_resp("fl5", 1, 0, 0);
    chk("fl5_way", resp_way, 0);

    // Bypass and bad VA
    lookup("byp", 28'h1234567, 7'd0, 0, 0, 0, 0, 0);
    exp_resp("byp", 1, 0, 1);
    chk("byp_way", resp_way, 0);
    lookup("bad", 28'h3333, 7'd3, 0, 1, 1, 0, 0);
    exp_resp("bad", 0, 0, 0);

    // Privilege checks
    refill(28'h05, 7'd1, 2'd0, 1, 1, 1);
    refill(28'h06, 7'd1, 2'd3, 0, 1, 1);
    lookup("pum", 28'h05, 7'd1, 0, 1, 0, 1, 1);
    exp_resp("pum", 0, 1, 0);
    lookup("sup", 28'h05, 7'd1, 0, 1, 0, 1, 0);
    exp_resp("sup", 1, 0, 0);
    lookup("ust", 28'h05, 7'd1, 1, 1, 0, 0, 0);
    exp_resp("ust", 1, 0, 0);
    lookup("u0", 28'h06, 7'd1, 0, 1, 0, 0, 0);
    exp_resp("u0", 0, 1, 0);
    lookup("s_u0", 28'h06, 7'd1, 0, 1, 0, 1, 1);
    exp_resp("s_u0", 1, 0, 0);
    chk("s_u0_way", resp_way, 3);

    // Refill and request in the same cycle: request stalls one cycle
    @(negedge clk);
    refill_valid = 1; refill_vpn = 28'hAB; refill_asid = 7'd7; refill_way = 2'd2;
    refill_u = 1; refill_sw = 1; refill_d = 1;
    req_valid = 1; req_vpn = 28'hAB; req_asid = 7'd7; req_store = 0;
    ctl_vm_enabled = 1; ctl_bad_va = 0; ctl_priv_s = 0; ctl_pum = 0;
    #1 chk("cc_ready0", req_ready, 0);
    @(negedge clk);
    refill_valid = 0;
    #1 chk("cc_ready1", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    chk("cc_s1_novld", resp_valid, 0);
    @(negedge clk);
    chk("cc_vld", resp_valid, 1);
    exp_resp("cc", 1, 0, 0);
    chk("cc_way", resp_way, 2);

    // Full flush empties the set
    flush(1'b0, 7'd0);
    lookup("ffl", 28'h05, 7'd1, 0, 1, 0, 0, 0);
    exp_resp("ffl", 0, 1, 0);
    chk("ffl_repl", resp_repl_way, 0);

    // Flush and refill together: refilled entry survives
    @(negedge clk);
    flush_valid = 1; flush_asid_en = 0;
    refill_valid = 1; refill_vpn = 28'h07; refill_asid = 7'd2; refill_way = 2'd1;
    refill_u = 1; refill_sw = 1; refill_d = 1;
    @(negedge clk);
    flush_valid = 0; refill_valid = 0;
    lookup("flrf", 28'h07, 7'd2, 0, 1, 0, 0, 0);
    exp_resp("flrf", 1, 0, 0);
    chk("flrf_way", resp_way, 1);

    // Reset with a request in S1: no response, then cold miss
    refill(28'h05, 7'd1, 2'd0, 1, 1, 1);
    @(negedge clk);
    req_valid = 1; req_vpn = 28'h05; req_asid = 7'd1; req_store = 0;
    ctl_vm_enabled = 1; ctl_bad_va = 0; ctl_priv_s = 0; ctl_pum = 0;
    @(negedge clk);
    req_valid = 0;
    reset_n = 0;
    @(negedge clk);
    chk("mrst_vld0", resp_valid, 0);
    reset_n = 1;
    @(negedge clk);
    chk("mrst_vld1", resp_valid, 0);
    lookup("mrst", 28'h05, 7'd1, 0, 1, 0, 0, 0);
    exp_resp("mrst", 0, 1, 0);
    chk("mrst_repl", resp_repl_way, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
